// File: rtl/ar_addr_ctrl_pkg.sv
// Shared constants and state encoding for the auxiliary-register sequencer.
// Op codes, post-modify codes and FSM states used by the controller and its bench.
package ar_addr_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LAR  = 3'd1;
  localparam logic [2:0] OP_SAR  = 3'd2;
  localparam logic [2:0] OP_LARP = 3'd3;
  localparam logic [2:0] OP_IND  = 3'd4;

  localparam logic [1:0] MOD_NONE = 2'b00;
  localparam logic [1:0] MOD_INC  = 2'b01;
  localparam logic [1:0] MOD_DEC  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

endpackage

// File: rtl/ar_addr_ctrl_dffr.sv
// Enable register with asynchronous active-high reset to zero.
// Holds AR0, AR1 and ARP inside the auxiliary-register sequencer.
module dffr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ar_addr_ctrl.sv
// Auxiliary register sequencer: executes LAR/SAR/LARP directly in IDLE and runs
// indirect accesses as IDLE -> ISSUE (address out, wait ack) -> UPDATE (post-modify).
module ar_addr_ctrl
  import ar_addr_ctrl_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic          ar_sel,
  input  logic [1:0]    mod,
  input  logic          nxt_arp_en,
  input  logic          nxt_arp,
  input  logic [W-1:0]  lar_data,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ack,
  output logic [W-1:0]  sar_data,
  output logic          sar_valid,
  output logic          arp,
  output logic [W-1:0]  ar0,
  output logic [W-1:0]  ar1,
  output logic [1:0]    state_dbg
);

  // Handshake: an op transfers on a rising edge where op_valid && op_ready; the
  // decoder holds op_valid and its fields stable until then. addr_valid stays high
  // with addr_out stable until a rising edge where addr_valid && addr_ack.
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          addr_valid_q, addr_valid_d;
  logic [W-1:0]  sar_data_q, sar_data_d;
  logic          sar_valid_q, sar_valid_d;
  logic [1:0]    mod_q, mod_d;
  logic          nxt_arp_en_q, nxt_arp_en_d;
  logic          nxt_arp_q, nxt_arp_d;

  logic          ar0_en, ar1_en, arp_en;
  logic [W-1:0]  ar0_d, ar1_d;
  logic          arp_d;
  logic [W-1:0]  cur_ar, upd_ar;
  logic          accept;

  dffr #(.W(W)) u_ar0 (.clk(clk), .rst(reset), .en(ar0_en), .d(ar0_d), .q(ar0));
  dffr #(.W(W)) u_ar1 (.clk(clk), .rst(reset), .en(ar1_en), .d(ar1_d), .q(ar1));
  dffr #(.W(1)) u_arp (.clk(clk), .rst(reset), .en(arp_en), .d(arp_d), .q(arp));

  assign cur_ar = arp ? ar1 : ar0;
  assign accept = op_valid && op_ready;

  always_comb begin
    case (mod_q)
      MOD_INC: upd_ar = cur_ar + ONE_W;
      MOD_DEC: upd_ar = cur_ar - ONE_W;
      default: upd_ar = cur_ar;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    sar_data_d   = sar_data_q;
    sar_valid_d  = 1'b0;
    mod_d        = mod_q;
    nxt_arp_en_d = nxt_arp_en_q;
    nxt_arp_d    = nxt_arp_q;
    ar0_en       = 1'b0;
    ar1_en       = 1'b0;
    arp_en       = 1'b0;
    ar0_d        = ar0;
    ar1_d        = ar1;
    arp_d        = arp;
    op_ready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (accept) begin
          case (op_code)
            OP_LAR: begin
              if (ar_sel) begin
                ar1_en = 1'b1;
                ar1_d  = lar_data;
              end else begin
                ar0_en = 1'b1;
                ar0_d  = lar_data;
              end
            end
            OP_SAR: begin
              sar_data_d  = ar_sel ? ar1 : ar0;
              sar_valid_d = 1'b1;
            end
            OP_LARP: begin
              arp_en = 1'b1;
              arp_d  = ar_sel;
            end
            OP_IND: begin
              addr_d       = cur_ar[AW-1:0];
              addr_valid_d = 1'b1;
              mod_d        = mod;
              nxt_arp_en_d = nxt_arp_en;
              nxt_arp_d    = nxt_arp;
              state_d      = S_ISSUE;
            end
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        if (addr_ack) begin
          addr_valid_d = 1'b0;
          state_d      = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // The AR written is the one selected by ARP before any ARP reload.
        if (arp) begin
          ar1_en = 1'b1;
          ar1_d  = upd_ar;
        end else begin
          ar0_en = 1'b1;
          ar0_d  = upd_ar;
        end
        if (nxt_arp_en_q) begin
          arp_en = 1'b1;
          arp_d  = nxt_arp_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      sar_data_q   <= '0;
      sar_valid_q  <= 1'b0;
      mod_q        <= MOD_NONE;
      nxt_arp_en_q <= 1'b0;
      nxt_arp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      sar_data_q   <= sar_data_d;
      sar_valid_q  <= sar_valid_d;
      mod_q        <= mod_d;
      nxt_arp_en_q <= nxt_arp_en_d;
      nxt_arp_q    <= nxt_arp_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = addr_valid_q;
  assign sar_data   = sar_data_q;
  assign sar_valid  = sar_valid_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ar_addr_ctrl.sv
// Randomized scoreboard bench for ar_addr_ctrl: a register/ARP model predicts SAR data,
// indirect addresses and hold lengths; a monitor pops and compares as the DUT emits them.
module tb_ar_addr_ctrl;

  localparam int W  = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic          ar_sel;
  logic [1:0]    mod;
  logic          nxt_arp_en;
  logic          nxt_arp;
  logic [W-1:0]  lar_data;
  logic [AW-1:0] addr_out;
  logic          addr_valid;
  logic          addr_ack;
  logic [W-1:0]  sar_data;
  logic          sar_valid;
  logic          arp;
  logic [W-1:0]  ar0;
  logic [W-1:0]  ar1;
  logic [1:0]    state_dbg;

  ar_addr_ctrl #(.W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .ar_sel(ar_sel), .mod(mod), .nxt_arp_en(nxt_arp_en),
    .nxt_arp(nxt_arp), .lar_data(lar_data), .addr_out(addr_out),
    .addr_valid(addr_valid), .addr_ack(addr_ack), .sar_data(sar_data),
    .sar_valid(sar_valid), .arp(arp), .ar0(ar0), .ar1(ar1), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard ----------------
  logic [W-1:0]  m_ar [2];
  logic          m_arp;
  logic [W-1:0]  exp_q[$];       // expected sar_data per sar_valid pulse
  logic [AW-1:0] exp_addr_q[$];  // expected addr_out per indirect access
  int            exp_hold_q[$];  // expected cycles addr_valid stays high

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ar[0] = '0;
    m_ar[1] = '0;
    m_arp   = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_ar0"}, 32'(ar0), 32'(m_ar[0]));
    chk({tag, "_ar1"}, 32'(ar1), 32'(m_ar[1]));
    chk({tag, "_arp"}, 32'(arp), 32'(m_arp));
  endtask

  // Applies the architectural effect of an accepted op to the model.
  task automatic model_apply(input logic [2:0] c, input logic s, input logic [1:0] m,
                             input logic en, input logic na, input logic [W-1:0] d,
                             input int hold);
    case (c)
      3'd1: m_ar[s] = d;
      3'd2: exp_q.push_back(m_ar[s]);
      3'd3: m_arp = s;
      3'd4: begin
        exp_addr_q.push_back(m_ar[m_arp][AW-1:0]);
        if (hold > 0) exp_hold_q.push_back(hold);
        if (m == 2'b01) m_ar[m_arp] = m_ar[m_arp] + 1;
        else if (m == 2'b10) m_ar[m_arp] = m_ar[m_arp] - 1;
        if (en) m_arp = na;
      end
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  logic          prev_v = 1'b0;
  logic [AW-1:0] cur_addr;
  int            hold_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_v   = 1'b0;
      hold_cnt = 0;
    end else begin
      if (sar_valid) begin
        if (exp_q.size() == 0) chk("sar_valid_unexpected", 32'(sar_valid), 32'd0);
        else chk("sar_data", 32'(sar_data), 32'(exp_q.pop_front()));
      end
      if (addr_valid && !prev_v) begin
        hold_cnt = 1;
        if (exp_addr_q.size() == 0) chk("addr_valid_unexpected", 32'(addr_valid), 32'd0);
        else begin
          cur_addr = exp_addr_q.pop_front();
          chk("addr_out", 32'(addr_out), 32'(cur_addr));
        end
      end else if (addr_valid) begin
        hold_cnt++;
        chk("addr_stable", 32'(addr_out), 32'(cur_addr));
      end
      if (!addr_valid && prev_v) begin
        if (exp_hold_q.size() == 0) chk("addr_hold_unexpected", 32'(hold_cnt), 32'd0);
        else chk("addr_hold_cycles", 32'(hold_cnt), 32'(exp_hold_q.pop_front()));
      end
      prev_v = addr_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!op_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) chk({tag, "_ready_timeout"}, 32'(op_ready), 32'd1);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the op has finished.
  task automatic do_op(input logic [2:0] c, input logic s, input logic [1:0] m,
                       input logic en, input logic na, input logic [W-1:0] d,
                       input int ack_delay);
    wait_ready("op");
    op_valid = 1'b1; op_code = c; ar_sel = s; mod = m;
    nxt_arp_en = en; nxt_arp = na; lar_data = d;
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_apply(c, s, m, en, na, d, (c == 3'd4) ? ack_delay + 1 : 0);
    if (c == 3'd4) begin
      repeat (ack_delay) begin
        @(posedge clk); #1;
      end
      addr_ack = 1'b1;
      @(posedge clk); #1;
      addr_ack = 1'b0;
      chk("update_op_ready", 32'(op_ready), 32'd0);
      chk("update_addr_valid", 32'(addr_valid), 32'd0);
      @(posedge clk); #1;
      chk("ind_ready_again", 32'(op_ready), 32'd1);
    end else begin
      chk("idle_op_ready", 32'(op_ready), 32'd1);
    end
    chk_regs("op");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = '0; ar_sel = 1'b0; mod = '0;
    nxt_arp_en = 1'b0; nxt_arp = 1'b0; lar_data = '0; addr_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_addr_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr_out", 32'(addr_out), 32'd0);
    chk("rst_sar_valid", 32'(sar_valid), 32'd0);
    chk("rst_sar_data", 32'(sar_data), 32'd0);
    chk_regs("rst");

    // LAR then SAR of AR1
    do_op(3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 16'h1234, 0);
    do_op(3'd2, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 0);
    @(posedge clk); #1;
    chk("sar_pulse_one_cycle", 32'(sar_valid), 32'd0);

    // 0x00FF increment with ARP reload, ack on third cycle
    do_op(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h00FF, 0);
    do_op(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 0);
    do_op(3'd4, 1'b0, 2'b01, 1'b1, 1'b1, 16'h0000, 2);
    chk("inc_ar0_0100", 32'(ar0), 32'h0100);

    // AR1 wrap up, arp already 1
    do_op(3'd1, 1'b1, 2'b00, 1'b0, 1'b0, 16'hFFFF, 0);
    do_op(3'd4, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 0);
    chk("wrap_ar1_0000", 32'(ar1), 32'h0000);

    // AR0 wrap down
    do_op(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 0);
    do_op(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 0);
    do_op(3'd4, 1'b0, 2'b10, 1'b0, 1'b1, 16'h0000, 1);
    chk("wrap_ar0_ffff", 32'(ar0), 32'hFFFF);

    // LARP held by decoder while an IND is in ISSUE
    wait_ready("held");
    op_valid = 1'b1; op_code = 3'd4; ar_sel = 1'b0; mod = 2'b01;
    nxt_arp_en = 1'b0; nxt_arp = 1'b1;
    @(posedge clk); #1;
    model_apply(3'd4, 1'b0, 2'b01, 1'b0, 1'b1, 16'h0000, 3);
    op_code = 3'd3; ar_sel = 1'b1;
    repeat (2) begin
      chk("held_not_ready", 32'(op_ready), 32'd0);
      chk("held_arp", 32'(arp), 32'(m_arp));
      @(posedge clk); #1;
    end
    addr_ack = 1'b1;
    @(posedge clk); #1;
    addr_ack = 1'b0;
    chk("held_update_not_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    chk("held_ready", 32'(op_ready), 32'd1);
    chk("held_arp_before_accept", 32'(arp), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    m_arp = 1'b1;
    chk_regs("held_accept");

    // addr_ack in IDLE is ignored
    addr_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    addr_ack = 1'b0;
    chk("idle_ack_addr_valid", 32'(addr_valid), 32'd0);
    chk("idle_ack_ready", 32'(op_ready), 32'd1);
    chk_regs("idle_ack");

    // Reset while an IND sits in ISSUE
    do_op(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0010, 0);
    do_op(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 0);
    op_valid = 1'b1; op_code = 3'd4; mod = 2'b01; nxt_arp_en = 1'b1; nxt_arp = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    exp_addr_q.push_back(8'h10);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_addr_valid", 32'(addr_valid), 32'd0);
    chk("midrst_ar0", 32'(ar0), 32'd0);
    chk("midrst_arp", 32'(arp), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_op_ready", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    chk_regs("midrst_after");

    // Randomized op mix
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   rc;
      logic [W-1:0] rd;
      rc = 3'($urandom_range(0, 7));
      rd = 16'($urandom_range(0, 65535));
      if (i % 8 == 0) rd = 16'hFFFF;
      if (i % 8 == 4) rd = 16'h0000;
      do_op(rc, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
            $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sar_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("hold_queue_drained", 32'(exp_hold_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1, "timeout");
  end

endmodule
